// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths,
// FSM state encoding and the canonical NOP word.
package instr_fetch_ctrl_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_INC  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // PA-RISC "OR 0,0,0" canonical no-op.
    localparam logic [31:0] NOP_WORD = 32'h0800_0240;

endpackage

// File: rtl/instr_fetch_ctrl_pc_offset_queue.sv
// PA-RISC PC offset queue: front is the address being fetched, back is the
// address that follows it (sequential successor or a pending branch target).
module pc_offset_queue
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_advance,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_target,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_target,
    output logic [ADDR_W-1:0] o_pc_front,
    output logic [ADDR_W-1:0] o_pc_back
);

    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0] r_front;
    logic [ADDR_W-1:0] r_back;
    logic [ADDR_W-1:0] w_front_next;
    logic [ADDR_W-1:0] w_back_next;
    logic [ADDR_W-1:0] w_redirect_aligned;
    logic [ADDR_W-1:0] w_flush_aligned;

    assign w_redirect_aligned = i_redirect_target & ALIGN_MASK;
    assign w_flush_aligned    = i_flush_target & ALIGN_MASK;

    // Flush wins over everything; a redirect that misses its delay-slot fetch
    // only replaces back so the slot at front is still issued.
    always_comb begin
        // NOTE: defaults first so every path assigns both nets and no latch is inferred.
        w_front_next = r_front;
        w_back_next  = r_back;
        if (i_flush) begin
            w_front_next = w_flush_aligned;
            w_back_next  = w_flush_aligned + INC;
        end else if (i_redirect && i_advance) begin
            w_front_next = w_redirect_aligned;
            w_back_next  = w_redirect_aligned + INC;
        end else if (i_redirect) begin
            w_back_next  = w_redirect_aligned;
        end else if (i_advance) begin
            w_front_next = r_back;
            w_back_next  = r_back + INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_front <= RESET_PC;
            r_back  <= RESET_PC + INC;
        end else begin
            r_front <= w_front_next;
            r_back  <= w_back_next;
        end
    end

    assign o_pc_front = r_front;
    assign o_pc_back  = r_back;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: run/idle FSM, valid/ready output register for IF/ID and
// the PC offset queue that drives the combinational instruction memory.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = DEF_PC_INC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               flush_valid,
    input  logic [ADDR_W-1:0]  flush_target,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [INSTR_W-1:0] r_out_instr;
    logic               w_slot_free;
    logic               w_fetch;
    logic               w_busy;
    logic [ADDR_W-1:0]  w_pc_front;
    logic [ADDR_W-1:0]  w_pc_back;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en)  w_state_next = S_RUN;
            S_RUN:   if (!en) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == S_RUN);
        w_slot_free = ~r_out_valid | out_ready;
        w_fetch     = w_busy & w_slot_free & ~flush_valid;
    end

    // Acceptance is honoured in IDLE too, so an entry held when en drops
    // still drains; a flush kills it regardless of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
        end else if (flush_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= w_pc_front;
            r_out_instr <= imem_data;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    pc_offset_queue #(
        .ADDR_W   (ADDR_W),
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) u_pcq (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_advance         (w_fetch),
        .i_redirect        (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_flush           (flush_valid),
        .i_flush_target    (flush_target),
        .o_pc_front        (w_pc_front),
        .o_pc_back         (w_pc_back)
    );

    assign imem_addr = w_pc_front;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_instr = r_out_instr;
    assign busy      = w_busy;

    logic w_unused;
    assign w_unused = ^w_pc_back;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model.
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        flush_valid;
    logic [7:0]  flush_target;
    logic        busy;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit        m_run;
    bit        m_valid;
    bit [7:0]  m_front;
    bit [7:0]  m_back;
    bit [7:0]  m_pc;
    bit [31:0] m_instr;

    instr_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush_valid     (flush_valid),
        .flush_target    (flush_target),
        .busy            (busy)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_valid = 1'b0;
        m_front = 8'h00;
        m_back  = 8'h04;
        m_pc    = 8'h00;
        m_instr = 32'h0;
    endtask

    task automatic check_model(input string where);
        check({where, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, m_front});
        check({where, ".out_valid"}, {31'h0, out_valid}, {31'h0, m_valid});
        check({where, ".out_pc"},    {24'h0, out_pc},    {24'h0, m_pc});
        check({where, ".out_instr"}, out_instr,          m_instr);
        check({where, ".busy"},      {31'h0, busy},      {31'h0, m_run});
    endtask

    // Apply one clock edge to both DUT and model, then compare everything.
    task automatic tick(input string where);
        bit       fetch;
        bit [7:0] ft;
        bit [7:0] rt;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            model_reset();
        end else begin
            fetch = m_run && (!m_valid || out_ready) && !flush_valid;
            ft    = flush_target & 8'hFC;
            rt    = redirect_target & 8'hFC;
            @(posedge clk);
            #1;
            if (flush_valid) begin
                m_valid = 1'b0;
                m_front = ft;
                m_back  = ft + 8'd4;
            end else begin
                if (fetch) begin
                    m_pc    = m_front;
                    m_instr = mem[m_front];
                    m_valid = 1'b1;
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
                if (redirect_valid && fetch) begin
                    m_front = rt;
                    m_back  = rt + 8'd4;
                end else if (redirect_valid) begin
                    m_back  = rt;
                end else if (fetch) begin
                    m_front = m_back;
                    m_back  = m_back + 8'd4;
                end
            end
            m_run = en;
        end
        check_model(where);
    endtask

    initial begin
        bit [7:0] wrap_seq [4];
        wrap_seq[0] = 8'hF8;
        wrap_seq[1] = 8'hFC;
        wrap_seq[2] = 8'h00;
        wrap_seq[3] = 8'h04;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = NOP_WORD;
        mem[4]  = 32'h1111_0004;
        mem[8]  = 32'h2222_0008;
        mem[12] = 32'h3333_000C;

        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00;
        flush_valid = 1'b0; flush_target = 8'h00;
        model_reset();
        #2;
        check("reset.out_valid", {31'h0, out_valid}, 32'h0);
        check("reset.imem_addr", {24'h0, imem_addr}, 32'h0);
        check("reset.out_pc",    {24'h0, out_pc},    32'h0);
        check("reset.out_instr", out_instr,          32'h0);
        check("reset.busy",      {31'h0, busy},      32'h0);
        tick("reset_hold");
        tick("reset_hold");
        rst_n = 1'b1;

        // Idle with fetch disabled
        for (int i = 0; i < 5; i++) begin
            tick("idle");
            check("idle.imem_addr", {24'h0, imem_addr}, 32'h0);
            check("idle.out_valid", {31'h0, out_valid}, 32'h0);
        end

        // Sequential fetch
        en = 1'b1; out_ready = 1'b1;
        tick("start");
        check("start.busy", {31'h0, busy}, 32'h1);
        tick("seq");
        check("seq0.out_pc", {24'h0, out_pc}, 32'h00);
        check("seq0.out_instr", out_instr, NOP_WORD);
        tick("seq");
        check("seq1.out_pc", {24'h0, out_pc}, 32'h04);
        check("seq1.out_instr", out_instr, 32'h1111_0004);

        // Backpressure at pc=4
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.out_pc", {24'h0, out_pc}, 32'h04);
            check("stall.imem_addr", {24'h0, imem_addr}, 32'h08);
        end
        out_ready = 1'b1;
        tick("release");
        check("release.out_pc", {24'h0, out_pc}, 32'h08);
        check("release.out_instr", out_instr, 32'h2222_0008);

        // Delayed branch with delay slot fetched in the same cycle
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick("br");
        redirect_valid = 1'b0;
        check("br.slot_pc", {24'h0, out_pc}, 32'h0C);
        check("br.slot_instr", out_instr, 32'h3333_000C);
        tick("br");
        check("br.target_pc", {24'h0, out_pc}, 32'h40);
        tick("br");
        check("br.target_next", {24'h0, out_pc}, 32'h44);

        // Branch resolved during a stall: the delay slot still issues
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 8'h80;
        tick("br_stall");
        redirect_valid = 1'b0;
        tick("br_stall");
        check("br_stall.imem_addr", {24'h0, imem_addr}, 32'h48);
        out_ready = 1'b1;
        tick("br_stall");
        check("br_stall.slot_pc", {24'h0, out_pc}, 32'h48);
        tick("br_stall");
        check("br_stall.target_pc", {24'h0, out_pc}, 32'h80);

        // Flush overrides a simultaneous redirect
        flush_valid = 1'b1; flush_target = 8'h20;
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick("flush");
        flush_valid = 1'b0; redirect_valid = 1'b0;
        check("flush.out_valid", {31'h0, out_valid}, 32'h0);
        tick("flush");
        check("flush.pc0", {24'h0, out_pc}, 32'h20);
        tick("flush");
        check("flush.pc1", {24'h0, out_pc}, 32'h24);

        // Misaligned flush target is forced to a word boundary
        flush_valid = 1'b1; flush_target = 8'h23;
        tick("align");
        flush_valid = 1'b0;
        check("align.imem_addr", {24'h0, imem_addr}, 32'h20);
        tick("align");
        check("align.out_pc", {24'h0, out_pc}, 32'h20);

        // Address wrap modulo 256
        flush_valid = 1'b1; flush_target = 8'hF8;
        tick("wrap");
        flush_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("wrap");
            check("wrap.out_pc", {24'h0, out_pc}, {24'h0, wrap_seq[i]});
        end

        // en drops while an entry is stalled: it stays valid until accepted
        out_ready = 1'b0;
        tick("en_drop");
        en = 1'b0;
        tick("en_drop");
        check("en_drop.busy", {31'h0, busy}, 32'h0);
        check("en_drop.held_valid", {31'h0, out_valid}, 32'h1);
        check("en_drop.held_pc", {24'h0, out_pc}, 32'h04);
        tick("en_drop");
        out_ready = 1'b1;
        tick("en_drop");
        check("en_drop.drained", {31'h0, out_valid}, 32'h0);
        tick("en_drop");
        check("en_drop.no_fetch", {31'h0, out_valid}, 32'h0);

        // Flush honoured in IDLE
        flush_valid = 1'b1; flush_target = 8'h60;
        tick("idle_flush");
        flush_valid = 1'b0;
        check("idle_flush.imem_addr", {24'h0, imem_addr}, 32'h60);

        // Async reset between clock edges
        en = 1'b1;
        tick("pre_rst");
        tick("pre_rst");
        tick("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.out_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst.imem_addr", {24'h0, imem_addr}, 32'h0);
        check("async_rst.busy",      {31'h0, busy},      32'h0);
        tick("async_rst");
        rst_n = 1'b1;
        tick("restart");
        tick("restart");
        check("restart.out_pc", {24'h0, out_pc}, 32'h00);
        check("restart.out_valid", {31'h0, out_valid}, 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            en              = ($urandom_range(0, 9) != 0);
            out_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid  = ($urandom_range(0, 7) == 0);
            redirect_target = 8'($urandom);
            flush_valid     = ($urandom_range(0, 15) == 0);
            flush_target    = 8'($urandom);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
